// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - UART transmitter fed by a small word FIFO
// Sout is registered from the current state, so the line trails the FSM by one cycle.
module uart_tx_fifo #(
  parameter int CLK_DIV    = 5208,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        Reset,
  input  logic [DATA_BITS-1:0]        Din,
  input  logic                        Send,
  output logic                        Ready,
  output logic [$clog2(FIFO_DEPTH):0] Count,
  output logic                        Sout,
  output logic                        Busy,
  output logic                        Done
);
  localparam int PtrW = $clog2(FIFO_DEPTH);
  localparam int DivW = $clog2(CLK_DIV);
  localparam int IdxW = $clog2(DATA_BITS + 1);
  localparam logic [DivW-1:0] DivLast   = DivW'(CLK_DIV - 1);
  localparam logic [PtrW:0]   FullCount = (PtrW+1)'(FIFO_DEPTH);
  localparam logic [IdxW-1:0] DataLast  = IdxW'(DATA_BITS - 1);
  localparam logic [IdxW-1:0] StopLast  = IdxW'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} stateT;

  stateT                state;
  logic [DATA_BITS-1:0] fifoMem [FIFO_DEPTH];
  logic [PtrW-1:0]      wrPtr;
  logic [PtrW-1:0]      rdPtr;
  logic [DATA_BITS-1:0] headWord;
  logic [DATA_BITS-1:0] shiftReg;
  logic [DivW-1:0]      divCnt;
  logic [IdxW-1:0]      bitIdx;
  logic                 parBit;
  logic                 bitTick;
  logic                 push;
  logic                 pop;

  assign Ready    = (Count != FullCount);
  assign push     = Send && Ready && !Reset;
  assign headWord = fifoMem[rdPtr];
  assign bitTick  = (divCnt == DivLast);
  assign Busy     = (state != IDLE) || (Count != '0);

  // Pops happen only when the shifter is loaded: from IDLE, or at the end of the last stop bit.
  always_comb begin
    pop = 1'b0;
    if (Count != '0) begin
      if (state == IDLE) begin
        pop = 1'b1;
      end else if (state == STOP && bitTick && bitIdx == StopLast) begin
        pop = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifoMem[wrPtr] <= Din;
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      Count <= '0;
    end else begin
      if (push) begin
        wrPtr <= wrPtr + 1'b1;
      end
      if (pop) begin
        rdPtr <= rdPtr + 1'b1;
      end
      case ({push, pop})
        2'b10:   Count <= Count + 1'b1;
        2'b01:   Count <= Count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state    <= IDLE;
      shiftReg <= '0;
      parBit   <= 1'b0;
      bitIdx   <= '0;
      divCnt   <= '0;
      Sout     <= 1'b1;
      Done     <= 1'b0;
    end else begin
      Done <= 1'b0;
      // Every non-idle state exits on bitTick, so wrapping here also clears the timer on entry.
      divCnt <= (state == IDLE || bitTick) ? '0 : divCnt + 1'b1;
      if (pop) begin
        shiftReg <= headWord;
        parBit   <= (PARITY == 2) ? ~^headWord : ^headWord;
      end
      case (state)
        IDLE: begin
          Sout <= 1'b1;
          if (pop) begin
            state <= START;
          end
        end
        START: begin
          Sout <= 1'b0;
          if (bitTick) begin
            bitIdx <= '0;
            state  <= DATA;
          end
        end
        DATA: begin
          Sout <= shiftReg[0];
          if (bitTick) begin
            shiftReg <= shiftReg >> 1;
            if (bitIdx == DataLast) begin
              bitIdx <= '0;
              state  <= (PARITY != 0) ? PAR : STOP;
            end else begin
              bitIdx <= bitIdx + 1'b1;
            end
          end
        end
        PAR: begin
          Sout <= parBit;
          if (bitTick) begin
            bitIdx <= '0;
            state  <= STOP;
          end
        end
        STOP: begin
          Sout <= 1'b1;
          if (bitTick) begin
            if (bitIdx == StopLast) begin
              Done   <= 1'b1;
              bitIdx <= '0;
              state  <= pop ? START : IDLE;
            end else begin
              bitIdx <= bitIdx + 1'b1;
            end
          end
        end
        default: begin
          Sout  <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed bench for uart_tx_fifo across four parameter sets
// Instance 0: 8N1, 1: 8E1, 2: 8O1, 3: 5N2; all with 16 clocks per bit and a 4-deep FIFO.
module tb_uart_tx_fifo;
  logic       clk = 1'b0;
  logic       Reset;
  logic [7:0] din0, din1, din2;
  logic [4:0] din3;
  logic [3:0] send;
  logic [3:0] sout, busy, done, ready;
  logic [2:0] cnt0, cnt1, cnt2, cnt3;

  int total = 0;
  int bad = 0;

  uart_tx_fifo #(.CLK_DIV(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut0 (
    .clk(clk), .Reset(Reset), .Din(din0), .Send(send[0]), .Ready(ready[0]),
    .Count(cnt0), .Sout(sout[0]), .Busy(busy[0]), .Done(done[0]));
  uart_tx_fifo #(.CLK_DIV(16), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) dut1 (
    .clk(clk), .Reset(Reset), .Din(din1), .Send(send[1]), .Ready(ready[1]),
    .Count(cnt1), .Sout(sout[1]), .Busy(busy[1]), .Done(done[1]));
  uart_tx_fifo #(.CLK_DIV(16), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) dut2 (
    .clk(clk), .Reset(Reset), .Din(din2), .Send(send[2]), .Ready(ready[2]),
    .Count(cnt2), .Sout(sout[2]), .Busy(busy[2]), .Done(done[2]));
  uart_tx_fifo #(.CLK_DIV(16), .DATA_BITS(5), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) dut3 (
    .clk(clk), .Reset(Reset), .Din(din3), .Send(send[3]), .Ready(ready[3]),
    .Count(cnt3), .Sout(sout[3]), .Busy(busy[3]), .Done(done[3]));

  initial forever #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Passive 8N1 receiver on instance 0, sampling mid-bit on the falling edge.
  int         cyc = 0;
  logic       rxAct = 1'b0;
  int         rxCnt = 0;
  logic [9:0] rxSh = '0;
  logic [7:0] rxQ[$];
  int         startQ[$];
  int         frameErr = 0;

  always @(negedge clk) begin
    cyc++;
    if (Reset) begin
      rxAct = 1'b0;
    end else begin
      if (!rxAct && sout[0] == 1'b0) begin
        rxAct = 1'b1;
        rxCnt = 0;
        startQ.push_back(cyc);
      end else if (rxAct) begin
        rxCnt++;
      end
      if (rxAct && (rxCnt % 16) == 7) begin
        rxSh[rxCnt/16] = sout[0];
        if (rxCnt / 16 == 9) begin
          rxAct = 1'b0;
          rxQ.push_back(rxSh[8:1]);
          if (rxSh[0] != 1'b0 || rxSh[9] != 1'b1) frameErr++;
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic int getCount(input int i);
    case (i)
      0: return int'(cnt0);
      1: return int'(cnt1);
      2: return int'(cnt2);
      default: return int'(cnt3);
    endcase
  endfunction

  task automatic setDin(input int i, input logic [8:0] d);
    case (i)
      0: din0 = d[7:0];
      1: din1 = d[7:0];
      2: din2 = d[7:0];
      default: din3 = d[4:0];
    endcase
  endtask

  task automatic push(input int i, input logic [8:0] d);
    setDin(i, d);
    send[i] = 1'b1;
    step;
    send[i] = 1'b0;
  endtask

  task automatic waitStart(input int i, output int lat);
    lat = 0;
    while (sout[i] == 1'b1 && lat < 400) begin
      step;
      lat++;
    end
  endtask

  task automatic waitIdle(input int i, input string tag);
    int n = 0;
    while (busy[i] == 1'b1 && n < 2000) begin
      step;
      n++;
    end
    check({tag, " idle"}, int'(busy[i]), 0);
  endtask

  // Starts in cycle 1 of a frame; samples each bit mid-way and locates the Done pulse.
  task automatic checkFrame(input int i, input int nBits, input logic [15:0] exp, input string tag);
    int doneCnt = 0;
    int doneAt = -1;
    for (int k = 0; k < nBits * 16; k++) begin
      if ((k % 16) == 8) check($sformatf("%s bit%0d", tag, k / 16), int'(sout[i]), int'(exp[k/16]));
      if (done[i]) begin
        doneCnt++;
        doneAt = k + 1;
      end
      step;
    end
    check({tag, " done count"}, doneCnt, 1);
    check({tag, " done cycle"}, doneAt, nBits * 16);
  endtask

  task automatic checkRx(input logic [7:0] exp[$], input string tag);
    check({tag, " rx count"}, rxQ.size(), exp.size());
    check({tag, " frame errors"}, frameErr, 0);
    for (int j = 0; j < exp.size(); j++) begin
      if (j < rxQ.size()) check($sformatf("%s word%0d", tag, j), int'(rxQ[j]), int'(exp[j]));
      if (j > 0 && j < startQ.size())
        check($sformatf("%s gap%0d", tag, j), startQ[j] - startQ[j-1], 160);
    end
  endtask

  task automatic clearRx;
    rxQ.delete();
    startQ.delete();
    frameErr = 0;
  endtask

  typedef struct {
    int          inst;
    logic [8:0]  din;
    int          nBits;
    logic [15:0] bits;
  } vecT;

  vecT vecs[9];

  initial begin
    int lat;
    int doneSeen;
    int lowSeen;
    logic [7:0] expQ[$];

    vecs[0] = '{0, 9'h0A5, 10, 16'h034A};
    vecs[1] = '{0, 9'h000, 10, 16'h0200};
    vecs[2] = '{0, 9'h0FF, 10, 16'h03FE};
    vecs[3] = '{1, 9'h007, 11, 16'h060E};
    vecs[4] = '{1, 9'h003, 11, 16'h0406};
    vecs[5] = '{2, 9'h007, 11, 16'h040E};
    vecs[6] = '{2, 9'h000, 11, 16'h0600};
    vecs[7] = '{3, 9'h01F, 8,  16'h00FE};
    vecs[8] = '{3, 9'h00A, 8,  16'h00D4};

    din0 = 8'h5A; din1 = 8'h5A; din2 = 8'h5A; din3 = 5'h15;
    Reset = 1'b1;
    send = 4'hF;
    step;
    step;
    send = 4'h0;
    Reset = 1'b0;
    step;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("reset count%0d", i), getCount(i), 0);
      check($sformatf("reset sout%0d", i), int'(sout[i]), 1);
      check($sformatf("reset busy%0d", i), int'(busy[i]), 0);
      check($sformatf("reset ready%0d", i), int'(ready[i]), 1);
      check($sformatf("reset done%0d", i), int'(done[i]), 0);
    end

    for (int v = 0; v < 9; v++) begin
      push(vecs[v].inst, vecs[v].din);
      check($sformatf("vec%0d count", v), getCount(vecs[v].inst), 1);
      waitStart(vecs[v].inst, lat);
      check($sformatf("vec%0d latency", v), lat, 2);
      checkFrame(vecs[v].inst, vecs[v].nBits, vecs[v].bits, $sformatf("vec%0d", v));
      check($sformatf("vec%0d busy", v), int'(busy[vecs[v].inst]), 0);
    end

    clearRx();
    push(0, 9'h11);
    push(0, 9'h22);
    push(0, 9'h33);
    push(0, 9'h44);
    check("burst count4", getCount(0), 3);
    check("burst ready4", int'(ready[0]), 1);
    push(0, 9'h55);
    check("burst count5", getCount(0), 4);
    check("burst ready5", int'(ready[0]), 0);
    push(0, 9'h66);
    check("burst drop count", getCount(0), 4);
    waitIdle(0, "burst");
    repeat (4) step;
    expQ = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    checkRx(expQ, "burst");

    clearRx();
    push(0, 9'h81);
    push(0, 9'h42);
    push(0, 9'h24);
    check("pushpop pre count", getCount(0), 2);
    repeat (158) step;
    check("pushpop edge count", getCount(0), 2);
    check("pushpop edge done", int'(done[0]), 0);
    push(0, 9'h18);
    check("pushpop after count", getCount(0), 2);
    check("pushpop after done", int'(done[0]), 1);
    waitIdle(0, "pushpop");
    repeat (4) step;
    expQ = '{8'h81, 8'h42, 8'h24, 8'h18};
    checkRx(expQ, "pushpop");

    push(0, 9'h01);
    push(0, 9'h02);
    push(0, 9'h03);
    repeat (40) step;
    check("midrst busy before", int'(busy[0]), 1);
    Reset = 1'b1;
    step;
    check("midrst sout", int'(sout[0]), 1);
    check("midrst count", getCount(0), 0);
    check("midrst busy", int'(busy[0]), 0);
    check("midrst ready", int'(ready[0]), 1);
    check("midrst done", int'(done[0]), 0);
    Reset = 1'b0;
    doneSeen = 0;
    lowSeen = 0;
    for (int k = 0; k < 200; k++) begin
      step;
      if (done[0]) doneSeen++;
      if (!sout[0]) lowSeen++;
    end
    check("midrst quiet done", doneSeen, 0);
    check("midrst quiet sout", lowSeen, 0);
    push(0, 9'h03C);
    waitStart(0, lat);
    check("postrst latency", lat, 2);
    checkFrame(0, 10, 16'h0278, "postrst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
